getir_tamponu: RTL and testbench

- Fetch-side instruction buffer between instruction memory and the decode stage.
- Accepts fetched instruction words, each with its PC and the branch class that the predecoder computes combinationally on the same word.
- Applies static prediction: JAL always taken, backward conditional branch taken. Redirects the PC generator and drops wrong-path fetches until the target arrives.
- Buffers accepted instructions in a small FIFO; decode consumes them through a valid/ready handshake.

---
 rtl/getir_tamponu.sv | 230 +++++++++++++++++++++++
 tb/tb_getir_tamponu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/getir_tamponu.sv
// Fetch-side instruction buffer: accepts predecoded fetch words, applies static
// branch prediction (JAL / backward conditional taken), drops wrong-path words
// until the predicted target shows up, and queues the survivors for decode.

package oncoz_pkg;

    typedef enum logic [1:0] {
        DALLANMA_YOK = 2'd0,
        JAL          = 2'd1,
        JALR         = 2'd2,
        DALLANMA     = 2'd3
    } dallanma_turu_t;

endpackage

module getir_tamponu
    import oncoz_pkg::*;
#(
    parameter int DERINLIK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  getir_gecerli_i,
    input  logic [31:0]           getir_buyruk_i,
    input  logic [31:0]           getir_ps_i,
    input  dallanma_turu_t        dallanma_turu_i,
    output logic                  getir_hazir_o,

    output logic                  tahmin_gecerli_o,
    output logic [31:0]           tahmin_ps_o,

    output logic                  coz_gecerli_o,
    output logic [31:0]           coz_buyruk_o,
    output logic [31:0]           coz_ps_o,
    output logic                  coz_tahmin_atladi_o,
    input  logic                  coz_hazir_i,

    input  logic                  temizle_i
);

    localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam logic [AW:0] DOLU = (AW + 1)'(DERINLIK);

    typedef enum logic {
        NORMAL    = 1'b0,
        YONLENDIR = 1'b1
    } durum_t;

    // ------------------------------------------------------------------
    // Immediate decoding and target computation
    // ------------------------------------------------------------------

    // J-type immediate: {b31, b19:12, b20, b30:21, 0}, sign-extended.
    function automatic logic signed [31:0] j_imm(input logic [31:0] b);
        logic signed [31:0] imm;
        imm = {{12{b[31]}}, b[19:12], b[20], b[30:21], 1'b0};
        return imm;
    endfunction

    // B-type immediate: {b31, b7, b30:25, b11:8, 0}, sign-extended.
    function automatic logic signed [31:0] b_imm(input logic [31:0] b);
        logic signed [31:0] imm;
        imm = {{20{b[31]}}, b[7], b[30:25], b[11:8], 1'b0};
        return imm;
    endfunction

    // Static prediction: JAL always taken, conditional branch taken if backward.
    function automatic logic atlar_mi(input dallanma_turu_t tur, input logic [31:0] b);
        logic sonuc;
        unique case (tur)
            JAL:      sonuc = 1'b1;
            DALLANMA: sonuc = b[31];
            default:  sonuc = 1'b0;
        endcase
        return sonuc;
    endfunction

    // Predicted target; modulo-2^32 add of PC and the class-specific offset.
    function automatic logic [31:0] hedef_hesapla(input dallanma_turu_t tur,
                                                  input logic [31:0]     b,
                                                  input logic [31:0]     ps);
        logic signed [31:0] ofset;
        ofset = (tur == JAL) ? j_imm(b) : b_imm(b);
        return ps + $unsigned(ofset);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    logic [31:0]     buyruk_mem [DERINLIK];
    logic [31:0]     ps_mem     [DERINLIK];
    logic            atladi_mem [DERINLIK];

    logic [AW-1:0]   yaz_ptr;
    logic [AW-1:0]   oku_ptr;
    logic [AW:0]     sayac;

    durum_t          durum;
    durum_t          durum_sonraki;

    logic            getir_el_sikisma;
    logic            itme;
    logic            cekme;
    logic            atla;
    logic [31:0]     hedef;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------

    // Ready only from registered count; a full buffer refuses even while popping.
    assign getir_hazir_o    = (sayac != DOLU);
    assign coz_gecerli_o    = (sayac != '0);

    // Flush overrides both sides: neither a fetch nor a pop takes effect.
    assign getir_el_sikisma = getir_gecerli_i && getir_hazir_o && !temizle_i;
    assign cekme            = coz_gecerli_o && coz_hazir_i && !temizle_i;

    assign atla             = itme && atlar_mi(dallanma_turu_i, getir_buyruk_i);
    assign hedef            = hedef_hesapla(dallanma_turu_i, getir_buyruk_i, getir_ps_i);

    // ------------------------------------------------------------------
    // Redirect FSM
    // ------------------------------------------------------------------

    // Redirect state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum <= NORMAL;
        end else begin
            durum <= durum_sonraki;
        end
    end

    // Next state: a taken push (re)enters YONLENDIR, any other push returns to NORMAL.
    always_comb begin
        durum_sonraki = durum;
        if (temizle_i) begin
            durum_sonraki = NORMAL;
        end else if (itme) begin
            durum_sonraki = atla ? YONLENDIR : NORMAL;
        end
    end

    // Push decision: while redirecting, only the word at the predicted target survives.
    always_comb begin
        itme = 1'b0;
        if (getir_el_sikisma) begin
            unique case (durum)
                NORMAL:    itme = 1'b1;
                YONLENDIR: itme = (getir_ps_i == tahmin_ps_o);
                default:   itme = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Redirect pulse toward the PC generator
    // ------------------------------------------------------------------

    // One-cycle pulse after a taken push; the target is held until the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tahmin_gecerli_o <= 1'b0;
            tahmin_ps_o      <= '0;
        end else begin
            tahmin_gecerli_o <= atla;
            if (atla) begin
                tahmin_ps_o <= hedef;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayac   <= '0;
        end else if (temizle_i) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayac   <= '0;
        end else begin
            if (itme) begin
                yaz_ptr <= yaz_ptr + 1'b1;
            end
            if (cekme) begin
                oku_ptr <= oku_ptr + 1'b1;
            end
            unique case ({itme, cekme})
                2'b10:   sayac <= sayac + 1'b1;
                2'b01:   sayac <= sayac - 1'b1;
                default: sayac <= sayac;
            endcase
        end
    end

    // Storage write; contents need no reset because reads are gated by count.
    always_ff @(posedge clk_i) begin
        if (itme) begin
            buyruk_mem[yaz_ptr] <= getir_buyruk_i;
            ps_mem[yaz_ptr]     <= getir_ps_i;
            atladi_mem[yaz_ptr] <= atla;
        end
    end

    // ------------------------------------------------------------------
    // Head toward decode
    // ------------------------------------------------------------------

    // Zero-latency head read, forced to zero while the buffer is empty.
    always_comb begin
        coz_buyruk_o        = '0;
        coz_ps_o            = '0;
        coz_tahmin_atladi_o = 1'b0;
        if (coz_gecerli_o) begin
            coz_buyruk_o        = buyruk_mem[oku_ptr];
            coz_ps_o            = ps_mem[oku_ptr];
            coz_tahmin_atladi_o = atladi_mem[oku_ptr];
        end
    end

endmodule

// File: tb/tb_getir_tamponu.sv
// Directed bench for getir_tamponu: fill/drain, static prediction, wrong-path
// dropping, flush priority, simultaneous push/pop and asynchronous reset.

module tb_getir_tamponu;
    import oncoz_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  getir_gecerli;
    logic [31:0]           getir_buyruk;
    logic [31:0]           getir_ps;
    dallanma_turu_t        tur;
    logic                  getir_hazir;
    logic                  tahmin_gecerli;
    logic [31:0]           tahmin_ps;
    logic                  coz_gecerli;
    logic [31:0]           coz_buyruk;
    logic [31:0]           coz_ps;
    logic                  coz_atladi;
    logic                  coz_hazir;
    logic                  temizle;

    int compared   = 0;
    int mismatched = 0;

    getir_tamponu #(.DERINLIK(4)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .getir_gecerli_i     (getir_gecerli),
        .getir_buyruk_i      (getir_buyruk),
        .getir_ps_i          (getir_ps),
        .dallanma_turu_i     (tur),
        .getir_hazir_o       (getir_hazir),
        .tahmin_gecerli_o    (tahmin_gecerli),
        .tahmin_ps_o         (tahmin_ps),
        .coz_gecerli_o       (coz_gecerli),
        .coz_buyruk_o        (coz_buyruk),
        .coz_ps_o            (coz_ps),
        .coz_tahmin_atladi_o (coz_atladi),
        .coz_hazir_i         (coz_hazir),
        .temizle_i           (temizle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ps, input logic [31:0] b, input dallanma_turu_t t);
        getir_gecerli = 1'b1;
        getir_ps      = ps;
        getir_buyruk  = b;
        tur           = t;
    endtask

    task automatic idle();
        getir_gecerli = 1'b0;
        getir_ps      = '0;
        getir_buyruk  = '0;
        tur           = DALLANMA_YOK;
    endtask

    initial begin
        rst_n     = 1'b1;
        coz_hazir = 1'b0;
        temizle   = 1'b0;
        idle();
        #1 rst_n = 1'b0;
        #2;

        // Reset values
        chk("rst_getir_hazir", 32'(getir_hazir), 32'd1);
        chk("rst_coz_gecerli", 32'(coz_gecerli), 32'd0);
        chk("rst_tahmin_gec", 32'(tahmin_gecerli), 32'd0);
        chk("rst_tahmin_ps", tahmin_ps, 32'h0);
        chk("rst_coz_buyruk", coz_buyruk, 32'h0);
        chk("rst_coz_ps", coz_ps, 32'h0);
        chk("rst_coz_atladi", 32'(coz_atladi), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Sequential fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            fetch(32'(4 * i), 32'h0000_0013, DALLANMA_YOK);
            chk("fill_hazir", 32'(getir_hazir), 32'd1);
            step();
        end
        chk("full_hazir", 32'(getir_hazir), 32'd0);
        chk("full_head_ps", coz_ps, 32'h0);
        fetch(32'h10, 32'h0000_0013, DALLANMA_YOK);
        step();
        idle();
        coz_hazir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_gecerli", 32'(coz_gecerli), 32'd1);
            chk("drain_ps", coz_ps, 32'(4 * i));
            chk("drain_buyruk", coz_buyruk, 32'h0000_0013);
            step();
        end
        chk("drain_empty", 32'(coz_gecerli), 32'd0);
        coz_hazir = 1'b0;

        // JAL taken: redirect pulse, wrong-path drop, target accepted
        fetch(32'h100, 32'h0200_006F, JAL);
        step();
        chk("jal_pulse", 32'(tahmin_gecerli), 32'd1);
        chk("jal_target", tahmin_ps, 32'h120);
        fetch(32'h104, 32'h0000_0013, DALLANMA_YOK);
        step();
        chk("jal_pulse_once", 32'(tahmin_gecerli), 32'd0);
        chk("jal_target_hold", tahmin_ps, 32'h120);
        fetch(32'h108, 32'h0000_0013, DALLANMA_YOK);
        step();
        fetch(32'h120, 32'h0000_0013, DALLANMA_YOK);
        step();
        idle();
        chk("jal_head_ps", coz_ps, 32'h100);
        chk("jal_head_b", coz_buyruk, 32'h0200_006F);
        chk("jal_head_atl", 32'(coz_atladi), 32'd1);
        coz_hazir = 1'b1;
        step();
        chk("jal_tgt_ps", coz_ps, 32'h120);
        chk("jal_tgt_atl", 32'(coz_atladi), 32'd0);
        step();
        chk("jal_drained", 32'(coz_gecerli), 32'd0);
        coz_hazir = 1'b0;

        // Backward BEQ taken, forward BNE and JALR not taken
        fetch(32'h200, 32'hFE00_0CE3, DALLANMA);
        step();
        chk("beq_pulse", 32'(tahmin_gecerli), 32'd1);
        chk("beq_target", tahmin_ps, 32'h1F8);
        fetch(32'h1F8, 32'h0000_0013, DALLANMA_YOK);
        step();
        chk("beq_pulse_once", 32'(tahmin_gecerli), 32'd0);
        fetch(32'h300, 32'h0000_1463, DALLANMA);
        step();
        chk("bne_no_pulse", 32'(tahmin_gecerli), 32'd0);
        chk("bne_ps_hold", tahmin_ps, 32'h1F8);
        fetch(32'h400, 32'h0000_8067, JALR);
        step();
        chk("jalr_no_pulse", 32'(tahmin_gecerli), 32'd0);
        chk("four_full", 32'(getir_hazir), 32'd0);
        idle();
        coz_hazir = 1'b1;
        chk("q0_ps", coz_ps, 32'h200);
        chk("q0_atl", 32'(coz_atladi), 32'd1);
        step();
        chk("q1_ps", coz_ps, 32'h1F8);
        chk("q1_atl", 32'(coz_atladi), 32'd0);
        step();
        chk("q2_ps", coz_ps, 32'h300);
        chk("q2_atl", 32'(coz_atladi), 32'd0);
        step();
        chk("q3_ps", coz_ps, 32'h400);
        chk("q3_atl", 32'(coz_atladi), 32'd0);
        step();
        coz_hazir = 1'b0;
        fetch(32'h404, 32'h0000_0013, DALLANMA_YOK);
        step();
        idle();
        chk("jalr_next_ps", coz_ps, 32'h404);
        chk("jalr_next_atl", 32'(coz_atladi), 32'd0);
        coz_hazir = 1'b1;
        step();
        coz_hazir = 1'b0;
        chk("jalr_drained", 32'(coz_gecerli), 32'd0);

        // Flush beats a simultaneous taken push and pop
        for (int i = 0; i < 3; i++) begin
            fetch(32'(4 * i), 32'h0000_0013, DALLANMA_YOK);
            step();
        end
        fetch(32'h100, 32'h0200_006F, JAL);
        coz_hazir = 1'b1;
        temizle   = 1'b1;
        step();
        temizle   = 1'b0;
        coz_hazir = 1'b0;
        chk("flush_empty", 32'(coz_gecerli), 32'd0);
        chk("flush_hazir", 32'(getir_hazir), 32'd1);
        chk("flush_no_pulse", 32'(tahmin_gecerli), 32'd0);
        chk("flush_ps_kept", tahmin_ps, 32'h1F8);
        fetch(32'h104, 32'h0000_0013, DALLANMA_YOK);
        step();
        idle();
        chk("flush_normal_ps", coz_ps, 32'h104);
        chk("flush_normal_v", 32'(coz_gecerli), 32'd1);
        coz_hazir = 1'b1;
        step();
        coz_hazir = 1'b0;

        // Push and pop together at count 2
        fetch(32'h10, 32'h0000_0013, DALLANMA_YOK);
        step();
        fetch(32'h14, 32'h0000_0013, DALLANMA_YOK);
        step();
        fetch(32'h18, 32'h0000_0013, DALLANMA_YOK);
        coz_hazir = 1'b1;
        step();
        idle();
        chk("pp_head", coz_ps, 32'h14);
        step();
        chk("pp_second", coz_ps, 32'h18);
        step();
        chk("pp_count2", 32'(coz_gecerli), 32'd0);
        coz_hazir = 1'b0;

        // Asynchronous reset in the middle of a burst
        fetch(32'h20, 32'h0000_0013, DALLANMA_YOK);
        step();
        fetch(32'h100, 32'h0200_006F, JAL);
        step();
        idle();
        chk("pre_rst_pulse", 32'(tahmin_gecerli), 32'd1);
        chk("pre_rst_count", 32'(coz_gecerli), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pulse", 32'(tahmin_gecerli), 32'd0);
        chk("arst_ps", tahmin_ps, 32'h0);
        chk("arst_gecerli", 32'(coz_gecerli), 32'd0);
        chk("arst_hazir", 32'(getir_hazir), 32'd1);
        chk("arst_coz_ps", coz_ps, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
